// File: rtl/alu_mp_sequencer.sv
// Multi-precision sequencer: runs one NBYTES-wide AND/OR/ADD/SUB/CMP through the shared 8-bit ALU, LSB byte first.
// Define ALU_SEQ_OVF_EN to add the signed-overflow output ovf.
module alu_mp_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [2:0]            alu_cs,
    output logic                  alu_cin,
    input  logic [7:0]            alu_s,
    input  logic                  alu_cout,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry,
    output logic                  zero,
    output logic                  err,
    output logic                  ready,
    output logic                  done
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3, OP_CMP = 3'd4
    } op_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_op;
    logic [W-1:0]    r_opa, r_opb;      // shift right one byte per RUN cycle; byte 0 feeds the ALU
    logic [W-1:0]    r_result, w_result_nxt;
    logic [IW-1:0]   r_idx;
    logic            r_chain, w_chain_nxt;
    logic            r_carry, r_zero, r_err;
    logic            w_accept, w_last, w_arith, w_rsvd;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_rsvd   = (r_op > OP_CMP);
    assign w_arith  = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_CMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_op)
            OP_OR:          alu_cs = 3'b001;
            OP_ADD:         alu_cs = 3'b110;
            OP_SUB, OP_CMP: alu_cs = 3'b101;
            default:        alu_cs = 3'b000;
        endcase
    end

    assign alu_a   = r_opa[7:0];
    assign alu_b   = r_opb[7:0];
    assign alu_cin = r_chain;

    // The chain is kept as a borrow in subtract modes; the ALU reports carry_out=1 for no borrow.
    always_comb begin
        case (r_op)
            OP_ADD:         w_chain_nxt = alu_cout;
            OP_SUB, OP_CMP: w_chain_nxt = ~alu_cout;
            default:        w_chain_nxt = 1'b0;
        endcase
    end

    always_comb begin
        w_result_nxt = r_result;
        if (w_rsvd)
            w_result_nxt = '0;
        else if (r_op == OP_CMP) begin
            if (w_last) w_result_nxt = W'(w_chain_nxt);
        end else
            w_result_nxt[{r_idx, 3'b000} +: 8] = alu_s;
    end

`ifdef ALU_SEQ_OVF_EN
    logic r_ovf, w_ovf_nxt, w_sign_b;
    assign w_sign_b  = (r_op == OP_SUB) ? ~r_opb[7] : r_opb[7];
    assign w_ovf_nxt = ((r_op == OP_ADD) || (r_op == OP_SUB)) &&
                       (r_opa[7] == w_sign_b) && (alu_s[7] != r_opa[7]);
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_ovf <= 1'b0;
        else if ((r_state == S_RUN) && w_last)   r_ovf <= w_ovf_nxt;
    end
`endif

    // NOTE: every datapath register is reset, so an aborted op leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_chain  <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_op    <= op;
            r_opa   <= opa;
            r_opb   <= opb;
            r_chain <= ((op == OP_ADD) || (op == OP_SUB)) ? cin : 1'b0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_result <= w_result_nxt;
            if (w_last) begin
                r_carry <= w_arith ? w_chain_nxt : 1'b0;
                r_zero  <= ~|w_result_nxt;
                r_err   <= w_rsvd;
                r_idx   <= '0;
            end else begin
                r_idx   <= r_idx + 1'b1;
                r_chain <= w_chain_nxt;
                r_opa   <= r_opa >> 8;
                r_opb   <= r_opb >> 8;
            end
        end
    end

    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;
    assign err    = r_err;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Bench for alu_mp_sequencer (NBYTES=4) with an 8-bit ALU model, vector table, corner sequences and random ops.
module tb_alu_mp_sequencer;

    localparam int NBYTES = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, cin;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic [7:0]  alu_a, alu_b, alu_s;
    logic [2:0]  alu_cs;
    logic        alu_cin, alu_cout;
    logic [31:0] result;
    logic        carry, zero, err, ready, done;
    logic        ovf_w;
    logic [8:0]  alu_tmp;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_mp_sequencer #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin),
        .opa(opa), .opb(opb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cs(alu_cs), .alu_cin(alu_cin),
        .alu_s(alu_s), .alu_cout(alu_cout),
        .result(result), .carry(carry), .zero(zero), .err(err),
        .ready(ready), .done(done)
`ifdef ALU_SEQ_OVF_EN
        , .ovf(ovf_w)
`endif
    );
`ifndef ALU_SEQ_OVF_EN
    assign ovf_w = 1'b0;
`endif

    always #5 clk = ~clk;

    // Shared 8-bit ALU; carry_out is junk (1) in logic modes.
    always_comb begin
        alu_tmp  = '0;
        alu_s    = '0;
        alu_cout = 1'b1;
        case (alu_cs)
            3'b110: begin
                alu_tmp  = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
                alu_s    = alu_tmp[7:0];
                alu_cout = alu_tmp[8];
            end
            3'b101: begin
                alu_tmp  = {1'b0, alu_a} - {1'b0, alu_b} - 9'(alu_cin);
                alu_s    = alu_tmp[7:0];
                alu_cout = ~alu_tmp[8];
            end
            3'b000:  alu_s = alu_a & alu_b;
            3'b001:  alu_s = alu_a | alu_b;
            default: alu_s = '0;
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic        cin;
        logic [31:0] a, b, res;
        logic        carry, zero, err;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        carry, zero, err, ovf;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-word reference: plain 33-bit arithmetic, no byte stepping.
    function automatic exp_t model(input logic [2:0] o, input logic ci, input logic [31:0] a, input logic [31:0] b);
        exp_t        x;
        logic [32:0] t;
        x = '{res: 32'h0, carry: 1'b0, zero: 1'b0, err: 1'b0, ovf: 1'b0};
        case (o)
            3'd0: x.res = a & b;
            3'd1: x.res = a | b;
            3'd2: begin
                t       = {1'b0, a} + {1'b0, b} + 33'(ci);
                x.res   = t[31:0];
                x.carry = t[32];
                x.ovf   = (a[31] == b[31]) && (t[31] != a[31]);
            end
            3'd3: begin
                t       = {1'b0, a} - {1'b0, b} - 33'(ci);
                x.res   = t[31:0];
                x.carry = t[32];
                x.ovf   = (a[31] != b[31]) && (t[31] != a[31]);
            end
            3'd4: begin
                x.carry = (a < b);
                x.res   = 32'(a < b);
            end
            default: x.err = 1'b1;
        endcase
        x.zero = (x.res == 32'h0);
        return x;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic ci, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output logic [31:0] r, output logic c, output logic z,
                          output logic e, output logic v);
        int n;
        n = 0;
        while (!ready && n < 16) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
        @(negedge clk);
        start = 1'b1; op = o; cin = ci; opa = a; opb = b;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        opa = $urandom; opb = $urandom; cin = ~ci;   // operands must already be latched
        n = 0;
        while (!done && n < 3 * NBYTES) begin
            check("ready_low_in_run", 32'(ready), 32'd0);
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(NBYTES));
        r = result; c = carry; z = zero; e = err; v = ovf_w;
        start = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(ready), 32'd1);
        check("result_held", result, r);
    endtask

    vec_t        vecs[14];
    exp_t        ex;
    logic [31:0] r;
    logic        c, z, e, v;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          n, dones;

    initial begin
        vecs[0]  = '{3'd2, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'd2, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'd3, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd4, 1'b0, 32'h00000003, 32'h00000005, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 1'b0, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{3'd6, 1'b0, 32'h00001234, 32'h00005678, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{3'd0, 1'b0, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd1, 1'b1, 32'h12000000, 32'h00000034, 32'h12000034, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd2, 1'b1, 32'h12345678, 32'h11111111, 32'h2345678A, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd3, 1'b1, 32'h00000010, 32'h00000005, 32'h0000000A, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'd4, 1'b1, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'd3, 1'b1, 32'h00000005, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{3'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{3'd0, 1'b1, 32'h000000FF, 32'h0000000F, 32'h0000000F, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = '0; cin = 1'b0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_alu_ab", {16'h0, alu_a, alu_b}, 32'h0);
        check("rst_alu_cs_cin", {28'h0, alu_cs, alu_cin}, 32'h0);
        check("rst_ovf", 32'(ovf_w), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b, 1'b0, r, c, z, e, v);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].carry));
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].zero));
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
        end

        // ALU byte drive, running carry, and hold after the op
        @(negedge clk);
        start = 1'b1; op = 3'd2; cin = 1'b1; opa = 32'h44332211; opb = 32'h88776655;
        @(posedge clk); #1;
        start = 1'b0;
        check("drv0_ab", {16'h0, alu_a, alu_b}, 32'h00001155);
        check("drv0_cs_cin", {28'h0, alu_cs, alu_cin}, 32'h0000000D);
        @(posedge clk); #1;
        check("drv1_ab", {16'h0, alu_a, alu_b}, 32'h00002266);
        check("drv1_cin", 32'(alu_cin), 32'd0);
        n = 0;
        while (!done && n < 12) begin
            @(posedge clk); #1; n++;
        end
        check("drv_done_seen", 32'(done), 32'd1);
        check("drv_result", result, 32'hCCAA8867);
        @(posedge clk); #1;
        check("drv_hold_ab", {16'h0, alu_a, alu_b}, 32'h00004488);

        // start held high through the whole op
        run_op(3'd2, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b1, r, c, z, e, v);
        check("hold_result", r, 32'h00010000);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("hold_no_extra_done", 32'(dones), 32'd0);

        // reset while RUN is on byte 2
        @(negedge clk);
        start = 1'b1; op = 3'd2; cin = 1'b0; opa = 32'h01010101; opb = 32'h02020202;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_result", result, 32'h0);
        check("abort_flags", {28'h0, carry, zero, err, done}, 32'h00000004);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_alu", {5'h0, alu_cs, alu_cin, 7'h0, alu_a, alu_b}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(3'd3, 1'b0, 32'h00000100, 32'h00000001, 1'b0, r, c, z, e, v);
        check("after_abort_result", r, 32'h000000FF);
        check("after_abort_carry", 32'(c), 32'd0);

`ifdef ALU_SEQ_OVF_EN
        run_op(3'd2, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, r, c, z, e, v);
        check("ovf_add", 32'(v), 32'd1);
        run_op(3'd3, 1'b0, 32'h80000000, 32'h00000001, 1'b0, r, c, z, e, v);
        check("ovf_sub", 32'(v), 32'd1);
        run_op(3'd0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, r, c, z, e, v);
        check("ovf_and", 32'(v), 32'd0);
`endif

        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF << $urandom_range(0, 1) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
            c  = 1'($urandom);
            ex = model(ro, c, ra, rb);
            run_op(ro, c, ra, rb, 1'b0, r, c, z, e, v);
            check($sformatf("rnd%0d_op%0d_result", i, ro), r, ex.res);
            check($sformatf("rnd%0d_op%0d_flags", i, ro), {29'h0, c, z, e}, {29'h0, ex.carry, ex.zero, ex.err});
`ifdef ALU_SEQ_OVF_EN
            check($sformatf("rnd%0d_op%0d_ovf", i, ro), 32'(v), 32'(ex.ovf));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
